// File: rtl/astro_pkg.sv
// Shared state encoding, screen constants and the hitbox helper for the astro game engine.
package astro_pkg;

  localparam int unsigned XW          = 10;
  localparam int unsigned XW1         = XW + 1;
  localparam int unsigned SCORE_W     = 8;
  localparam int unsigned BUDGET_W    = 4;

  localparam int unsigned SHOT_Y0     = 430;
  localparam int unsigned SHIP_XMIN   = 30;
  localparam int unsigned SHIP_XMAX   = 610;
  localparam int unsigned SHIP_X0     = 400;
  localparam int unsigned SHOT_BUDGET = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // |a - b| <= half, evaluated one bit wider and signed so it never wraps.
  function automatic logic near(input logic [XW-1:0] a, input logic [XW-1:0] b,
                                input logic [XW-1:0] half);
    logic signed [XW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d <= $signed({1'b0, half})) && (d >= -$signed({1'b0, half}));
  endfunction

endpackage

// File: rtl/astro_target.sv
// One bouncing target: x position, travel direction, alive flag and round reload.
module astro_target
  import astro_pkg::*;
#(
  parameter int unsigned XMIN        = 202,
  parameter int unsigned XMAX        = 398,
  parameter int unsigned STEP        = 2,
  parameter bit          START_RIGHT = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_i,
  input  logic          reload_i,
  input  logic          move_i,
  input  logic          kill_i,
  output logic [XW-1:0] x_o,
  output logic          alive_o
);

  localparam logic [XW-1:0] X_START = START_RIGHT ? XW'(XMIN) : XW'(XMAX);

  logic [XW-1:0] x_q, x_d, x_step;
  logic          right_q, right_d;
  logic          alive_q, alive_d;

  assign x_step = right_q ? (x_q + XW'(STEP)) : (x_q - XW'(STEP));

  // A killed target freezes on the very tick it is hit.
  always_comb begin
    x_d     = x_q;
    right_d = right_q;
    alive_d = alive_q;
    if (reload_i) begin
      x_d     = X_START;
      right_d = START_RIGHT;
      alive_d = 1'b1;
    end else if (kill_i) begin
      alive_d = 1'b0;
    end else if (move_i && alive_q) begin
      x_d = x_step;
      if ((x_step == XW'(XMIN)) || (x_step == XW'(XMAX))) right_d = ~right_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= X_START;
      right_q <= START_RIGHT;
      alive_q <= 1'b1;
    end else if (tick_i) begin
      x_q     <= x_d;
      right_q <= right_d;
      alive_q <= alive_d;
    end
  end

  assign x_o     = x_q;
  assign alive_o = alive_q;

endmodule

// File: rtl/astro_game_engine.sv
// Astro shooter round engine: ship, single shot, NUM_TGT targets, score and round FSM.
// Optional ASTRO_SHOT_BUDGET_EN limits each round to a fixed number of launches.
module astro_game_engine
  import astro_pkg::*;
#(
  parameter int unsigned NUM_TGT   = 4,
  parameter int unsigned SHIP_STEP = 2,
  parameter int unsigned TGT_STEP  = 2,
  parameter int unsigned SHOT_STEP = 10,
  parameter int unsigned HALF      = 10,
  parameter int unsigned TGT_XMIN  = 202,
  parameter int unsigned TGT_XMAX  = 398,
  parameter int unsigned TGT_Y0    = 100,
  parameter int unsigned TGT_DY    = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_fire,
  output logic [1:0]            state,
  output logic [XW-1:0]         ship_x,
  output logic                  shot_active,
  output logic [XW-1:0]         shot_x,
  output logic [XW-1:0]         shot_y,
  output logic [XW*NUM_TGT-1:0] tgt_x,
  output logic [NUM_TGT-1:0]    tgt_alive,
  output logic [SCORE_W-1:0]    score,
  output logic                  round_done
);

  state_e               state_q, state_d;
  logic [XW-1:0]        ship_q, ship_d, shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic [XW1-1:0]       ship_up;
  logic                 shot_act_q, shot_act_d, done_q, done_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [NUM_TGT-1:0]   cand, kill, alive_left;
  logic                 play, reload, hit, launch, budget_ok, budget_out_c;

  assign play   = (state_q == ST_PLAY);
  assign reload = (state_q == ST_IDLE) && start;

  for (genvar i = 0; i < NUM_TGT; i++) begin : g_tgt
    localparam logic [XW-1:0] LANE = XW'(TGT_Y0 + i * TGT_DY);

    assign cand[i] = shot_act_q && tgt_alive[i] &&
                     near(shot_x_q, tgt_x[XW*i +: XW], XW'(HALF)) &&
                     near(shot_y_q, LANE, XW'(HALF));

    astro_target #(
      .XMIN       (TGT_XMIN),
      .XMAX       (TGT_XMAX),
      .STEP       (TGT_STEP),
      .START_RIGHT((i % 2) == 0)
    ) u_tgt (
      .clk     (clk),
      .reset   (reset),
      .tick_i  (tick),
      .reload_i(reload),
      .move_i  (play),
      .kill_i  (kill[i]),
      .x_o     (tgt_x[XW*i +: XW]),
      .alive_o (tgt_alive[i])
    );
  end

  // Lowest-index candidate wins: isolate the least significant set bit.
  assign kill       = cand & (~cand + NUM_TGT'(1)) & {NUM_TGT{play}};
  assign hit        = |kill;
  assign alive_left = tgt_alive & ~kill;
  assign launch     = play && !hit && !shot_act_q && btn_fire && !btn_left && !btn_right &&
                      budget_ok;
  assign ship_up    = {1'b0, ship_q} + XW1'(SHIP_STEP);

`ifdef ASTRO_SHOT_BUDGET_EN
  logic [BUDGET_W-1:0] budget_q, budget_d;

  always_comb begin
    budget_d = budget_q;
    if (reload)      budget_d = BUDGET_W'(SHOT_BUDGET);
    else if (launch) budget_d = budget_q - BUDGET_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)     budget_q <= BUDGET_W'(SHOT_BUDGET);
    else if (tick) budget_q <= budget_d;
  end

  assign budget_ok    = (budget_q != '0);
  assign budget_out_c = (budget_d == '0);
`else
  assign budget_ok    = 1'b1;
  assign budget_out_c = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ship_d     = ship_q;
    shot_act_d = shot_act_q;
    shot_x_d   = shot_x_q;
    shot_y_d   = shot_y_q;
    score_d    = score_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          shot_act_d = 1'b0;
        end
      end
      ST_PLAY: begin
        if (btn_right && !btn_left)
          ship_d = (ship_up > XW1'(SHIP_XMAX)) ? XW'(SHIP_XMAX) : ship_up[XW-1:0];
        else if (btn_left && !btn_right)
          ship_d = (ship_q < XW'(SHIP_XMIN + SHIP_STEP)) ? XW'(SHIP_XMIN)
                                                          : (ship_q - XW'(SHIP_STEP));
        if (hit) begin
          shot_act_d = 1'b0;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
        end else if (shot_act_q) begin
          if (shot_y_q < XW'(SHOT_STEP)) shot_act_d = 1'b0;
          else                           shot_y_d   = shot_y_q - XW'(SHOT_STEP);
        end else if (launch) begin
          shot_act_d = 1'b1;
          shot_x_d   = ship_q;
          shot_y_d   = XW'(SHOT_Y0);
        end
        if ((alive_left == '0) || (budget_out_c && !shot_act_d)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // round_done is a single-clock pulse, so it clears on every non-tick clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ship_q     <= XW'(SHIP_X0);
      shot_act_q <= 1'b0;
      shot_x_q   <= '0;
      shot_y_q   <= '0;
      score_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= tick && done_d;
      if (tick) begin
        state_q    <= state_d;
        ship_q     <= ship_d;
        shot_act_q <= shot_act_d;
        shot_x_q   <= shot_x_d;
        shot_y_q   <= shot_y_d;
        score_q    <= score_d;
      end
    end
  end

  assign state       = state_q;
  assign ship_x      = ship_q;
  assign shot_active = shot_act_q;
  assign shot_x      = shot_x_q;
  assign shot_y      = shot_y_q;
  assign score       = score_q;
  assign round_done  = done_q;

endmodule

// File: doc/astro_game_engine.md
ASTRO_GAME_ENGINE -- requirements
Module: astro_game_engine

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  NUM_TGT, 4, target count (1..8)
  SHIP_STEP, 2, ship px per tick
  TGT_STEP, 2, target px per tick
  SHOT_STEP, 10, shot px per tick
  HALF, 10, hitbox half-size
  TGT_XMIN, 202, TGT_XMAX, 398, target x bounds
  TGT_Y0, 100, TGT_DY, 60, lane y of target i = TGT_Y0 + i*TGT_DY
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  game clock
  reset  in  1  synchronous active-high reset
  tick  in  1  one-clk game-update strobe
  start  in  1  round start level
  btn_left, btn_right, btn_fire  in  1 each  debounced buttons
  state  out  2  IDLE=0, PLAY=1, DONE=2
  ship_x  out  10  ship centre x
  shot_active  out  1  shot in flight
  shot_x, shot_y  out  10 each  shot centre
  tgt_x  out  10*NUM_TGT  target i x at bits [10i+9:10i]
  tgt_alive  out  NUM_TGT  live-target mask
  score  out  8  hits this round
  round_done  out  1  one-clk pulse on PLAY->DONE
REQ-003 SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 All state SHALL update only on clk edges with tick=1, except round_done, which SHALL be deasserted on every other clk.
REQ-005 IDLE->PLAY SHALL occur on a tick with start=1; targets reload (REQ-013), score=0, shot cleared.
REQ-006 In PLAY, ship SHALL move +SHIP_STEP if btn_right&~btn_left, -SHIP_STEP if btn_left&~btn_right, clamped to [30,610]; both or neither SHALL hold.
REQ-007 Fire SHALL launch only when btn_fire&~btn_left&~btn_right&~shot_active: shot_x=ship_x, shot_y=430, shot_active=1; fire while active SHALL be ignored.
REQ-008 Active shot SHALL decrement shot_y by SHOT_STEP each tick; if shot_y<SHOT_STEP it SHALL instead clear shot_active.
REQ-009 Hit test SHALL use pre-update values: target i hit when alive, |shot_x-x_i|<=HALF, |shot_y-lane_i|<=HALF; differences computed in 11-bit signed, no wrap.
REQ-010 Multiple simultaneous candidates: only the lowest index SHALL be hit; that tick: alive[i]=0, shot_active=0, score+1 saturating at 255.
REQ-011 Live target SHALL move TGT_STEP in its direction; when the new x equals TGT_XMIN or TGT_XMAX its direction SHALL flip on the same tick; dead targets SHALL freeze.
REQ-012 When tgt_alive becomes all-zero, state SHALL go DONE and round_done pulse for one clk; DONE->IDLE on a tick with start=0.
REQ-013 Reload: even i at TGT_XMIN moving right, odd i at TGT_XMAX moving left, all alive.
REQ-014 In IDLE/DONE, ship, shot, targets and score SHALL hold.

Reset
REQ-015 Reset SHALL give: state=IDLE, ship_x=400, shot_active=0, shot_x=0, shot_y=0, score=0, round_done=0, targets per REQ-013; reset SHALL override tick and abort any round.

Configuration
REQ-016 With ASTRO_SHOT_BUDGET_EN defined, each round SHALL allow 8 launches (counter reloaded on IDLE->PLAY); when the counter is 0 and no shot is active, PLAY->DONE with round_done pulse; fire at 0 SHALL be ignored. Without it, launches SHALL be unlimited and DONE only per REQ-012.

Structure
REQ-017 Package astro_pkg SHALL hold the state encoding, screen constants (430, 30, 610, 400) and the budget value 8.
REQ-018 Sub-module astro_target SHALL implement one target's x, direction, alive and reload, instantiated NUM_TGT times; hit priority SHALL stay in the top level.

Verification
REQ-019 Reset, then tick with start=1 -> state=PLAY, tgt_x[0]=202, tgt_x[1]=398, tgt_alive=4'b1111, ship_x=400.
REQ-020 btn_right held 110 ticks -> ship_x stops at 610; both buttons held -> ship_x unchanged.
REQ-021 Fire at ship_x=400 -> shot_y=430, then 420 on next tick; second fire ignored; after shot_y=0 the next tick clears shot_active.
REQ-022 Force target 0 and target 1 in hitbox on the same tick -> only alive[0] cleared, score=1, shot cleared.
REQ-023 Hit all 4 targets -> state=DONE, round_done high for exactly one clk; start=0 tick -> IDLE.
REQ-024 With ASTRO_SHOT_BUDGET_EN, 8 misses -> DONE after the last shot expires, score=0.
